// File: rtl/mioc_test_pkg.sv
// Shared types and constants for the MIOC gate-under-test pattern sequencer.
package mioc_test_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      APPLY  = 3'd1,
      SETTLE = 3'd2,
      SAMPLE = 3'd3,
      DONE   = 3'd4
   } mioc_state_e;

   // Expected-z truth tables, bit i = expected z for input pattern i
   localparam logic [7:0] NOR3_TT  = 8'h01;
   localparam logic [7:0] NAND3_TT = 8'h7F;
   localparam logic [1:0] INV_TT   = 2'b01;

   localparam int unsigned SETTLE_CYCLES_DEF = 100;

   // Settle counter width; covers the full legal SETTLE_CYCLES range
   localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/mioc_sync2.sv
// Two-flop synchroniser for a single asynchronous input.
module mioc_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Shift the asynchronous input through two flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/mioc_gate_pattern_seq.sv
// Walks a gate under test through every input pattern, waits a settle
// interval, samples its output and compares against a truth table.
module mioc_gate_pattern_seq
   import mioc_test_pkg::*;
#(
   parameter int unsigned           N_IN          = 3,
   parameter int unsigned           SETTLE_CYCLES = SETTLE_CYCLES_DEF,
   parameter logic [(1<<N_IN)-1:0]  EXPECT        = NOR3_TT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic [N_IN-1:0]        gate_in,
   input  logic                   z,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [N_IN:0]          err_count,
   output logic [(1<<N_IN)-1:0]   fail_vec,
   output logic                   log_valid,
   output logic [N_IN-1:0]        log_pattern,
   output logic                   log_z,
   output logic                   log_err
);

   localparam int unsigned P  = 1 << N_IN;
   localparam int unsigned EW = N_IN + 1;

   // Reject illegal configurations at elaboration
   if (N_IN < 1 || N_IN > 4) begin : g_bad_n_in
      $error("mioc_gate_pattern_seq: N_IN must be in 1..4");
   end
   if (SETTLE_CYCLES < 3 || SETTLE_CYCLES > 65535) begin : g_bad_settle
      $error("mioc_gate_pattern_seq: SETTLE_CYCLES must be in 3..65535");
   end

   mioc_state_e       state_q, state_d;
   logic [N_IN-1:0]   pat_q, pat_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              z_s;
   logic              mism;

   logic [N_IN-1:0]   gate_in_d;
   logic              busy_d, done_d, pass_d;
   logic [EW-1:0]     err_d;
   logic [P-1:0]      fail_d;
   logic              log_valid_d, log_z_d, log_err_d;
   logic [N_IN-1:0]   log_pattern_d;

   // Bring the gate output into the clk domain
   mioc_sync2 u_sync_z (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (z),
      .q     (z_s)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state and next-output logic
   always_comb begin
      state_d       = state_q;
      pat_d         = pat_q;
      cnt_d         = cnt_q;
      gate_in_d     = gate_in;
      err_d         = err_count;
      fail_d        = fail_vec;
      log_valid_d   = 1'b0;
      log_pattern_d = log_pattern;
      log_z_d       = log_z;
      log_err_d     = log_err;
      mism          = z_s ^ EXPECT[pat_q];

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               pat_d     = '0;
               err_d     = '0;
               fail_d    = '0;
               gate_in_d = '0;
               state_d   = APPLY;
            end
         end
         APPLY: begin
            cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
            state_d = SETTLE;
         end
         SETTLE: begin
            if (cnt_q == '0) state_d = SAMPLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         SAMPLE: begin
            log_valid_d   = 1'b1;
            log_pattern_d = pat_q;
            log_z_d       = z_s;
            log_err_d     = mism;
            if (mism) begin
               err_d         = err_count + EW'(1);
               fail_d[pat_q] = 1'b1;
            end
            if (pat_q == N_IN'(P - 1)) begin
               gate_in_d = '0;
               state_d   = DONE;
            end else begin
               pat_d     = pat_q + N_IN'(1);
               gate_in_d = pat_d;
               state_d   = APPLY;
            end
         end
         default: begin
            gate_in_d = '0;
            state_d   = IDLE;
         end
      endcase

      busy_d = (state_d == APPLY) || (state_d == SETTLE) || (state_d == SAMPLE);
      done_d = (state_d == DONE);
      pass_d = done_d && (err_d == '0);
   end

   // Registered datapath and outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat_q       <= '0;
         cnt_q       <= '0;
         gate_in     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         err_count   <= '0;
         fail_vec    <= '0;
         log_valid   <= 1'b0;
         log_pattern <= '0;
         log_z       <= 1'b0;
         log_err     <= 1'b0;
      end else begin
         pat_q       <= pat_d;
         cnt_q       <= cnt_d;
         gate_in     <= gate_in_d;
         busy        <= busy_d;
         done        <= done_d;
         pass        <= pass_d;
         err_count   <= err_d;
         fail_vec    <= fail_d;
         log_valid   <= log_valid_d;
         log_pattern <= log_pattern_d;
         log_z       <= log_z_d;
         log_err     <= log_err_d;
      end
   end

endmodule

// File: doc/mioc_gate_pattern_seq.md
Name: mioc_gate_pattern_seq

Overview:
Synthesizable on-chip stimulus and response stage for MIOC gate-under-test characterisation. It sits directly upstream of a MOS gate cell such as the 3-input NMOS NOR and drives its inputs through every input combination. It waits a settle interval, samples the gate output through a synchroniser and compares it against a parameterised truth table. It reports a per-pattern log stream, an error count, a fail bitmap and pass/done flags, which replaces file-driven pattern application on silicon.

Parameters:
N_IN, 3, number of gate inputs; legal range 1..4; pattern count P = 2**N_IN.
SETTLE_CYCLES, 100, clk cycles between applying a pattern and sampling z; legal range 3..65535, elaborate-time error otherwise.
EXPECT, 8'b0000_0001, expected-z truth table of width P; bit i is the expected z for pattern i (default = NOR3).

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begin a run; sampled only in IDLE or DONE.
gate_in  output  N_IN  drives gate inputs; gate_in[N_IN-1]=in1 ... gate_in[0]=in3 (MSB first).
z  input  1  gate output; asynchronous to clk.
busy  output  1  high in APPLY, SETTLE and SAMPLE.
done  output  1  high in DONE.
pass  output  1  valid while done; 1 iff err_count==0.
err_count  output  N_IN+1  number of mismatching patterns in the current/last run.
fail_vec  output  P  bit i set iff pattern i mismatched.
log_valid  output  1  one-cycle pulse per sampled pattern.
log_pattern  output  N_IN  pattern index for the log beat.
log_z  output  1  sampled z for the log beat.
log_err  output  1  1 if log_z != EXPECT[log_pattern].

Behaviour:
- Reset is asynchronous, active-low. All outputs and registers go to 0 and the state goes to IDLE, including mid-run. After release, no run starts until start is seen.
- z passes through a 2-flop synchroniser (z_s). This is why SETTLE_CYCLES must be at least 3.
- States: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE: gate_in=0. If start=1 at an edge: pat<=0, err_count<=0, fail_vec<=0, go to APPLY.
- APPLY (1 cycle): gate_in<=pat, settle counter<=SETTLE_CYCLES-1, go to SETTLE.
- SETTLE: decrement the counter each cycle; when it reaches 0, go to SAMPLE. SETTLE lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle): register log_z<=z_s, log_pattern<=pat, log_err<=(z_s!=EXPECT[pat]), and pulse log_valid=1 for the following cycle.
  - On mismatch: err_count+=1 and fail_vec[pat]<=1.
  - If pat==P-1, go to DONE; otherwise pat<=pat+1 and go to APPLY.
- Each pattern takes SETTLE_CYCLES+2 cycles. Start accepted at edge k gives done=1 after edge k+P*(SETTLE_CYCLES+2), which is k+816 for the defaults.
- DONE: gate_in returns to 0. done=1 and pass=(err_count==0). Results hold until the next start.
  - start in DONE behaves as in IDLE: results clear and a new run begins.
- start while busy is ignored; there is no restart and no queueing.
- err_count saturates naturally: its maximum is P, which fits in N_IN+1 bits. pat never wraps within a run.
- gate_in is registered and glitch-free, and changes only on the edge entering APPLY, IDLE or DONE.

Decomposition:
- Package mioc_test_pkg holds:
  - the state enum (IDLE, APPLY, SETTLE, SAMPLE, DONE);
  - localparam truth tables NOR3_TT=8'h01, NAND3_TT=8'h7F, INV_TT=2'b01;
  - the SETTLE_CYCLES default.
- One sub-module, mioc_sync2: a 2-flop synchroniser with async active-low reset to 0, reused for z.

Test Plan:
1. Behavioural NOR3 model on gate_in, defaults, start pulse -> 8 log beats with log_z=1,0,0,0,0,0,0,0; done at start+816 cycles; pass=1; err_count=0; fail_vec=8'h00.
2. z tied to 0 -> log_err only on pattern 0; err_count=1; fail_vec=8'h01; pass=0.
3. NAND3 model connected, EXPECT=NOR3 -> patterns 1..6 mismatch; err_count=6; fail_vec=8'h7E; pass=0.
4. rst_n low during SETTLE of pattern 4 -> outputs 0 immediately without waiting for clk; state IDLE; a subsequent start gives the full clean run of scenario 1.
5. start held high throughout a run, then restart from DONE -> mid-run start has no effect; start in DONE clears err_count and fail_vec and a second run repeats scenario 1 timing exactly.
6. N_IN=1, SETTLE_CYCLES=3, EXPECT=2'b01 with inverter model -> 2 beats, 5 cycles per pattern, done at start+10, pass=1.
